// File: rtl/sim_exit_pkg.sv
// Shared types and helpers for the simulation exit / syscall controller.
package sim_exit_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SCAN     = 3'd1,
    REQ      = 3'd2,
    WAIT_RSP = 3'd3,
    DONE     = 3'd4
  } state_e;

  // Width of an index into n entries; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_exit_mailbox.sv
// One tohost mailbox: pending value plus sticky overrun/exited flags.
module sim_exit_mailbox #(
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 clear_i,
  input  logic                 set_exited_i,
  output logic                 pending_o,
  output logic [DataWidth-1:0] value_o,
  output logic                 overrun_o,
  output logic                 exited_o
);

  logic write_valid;
  logic accept;

  always_comb begin
    write_valid = we_i && (wdata_i != '0);
    // A clear in the same cycle frees the slot, so the write still lands.
    accept      = write_valid && (!pending_o || clear_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_o <= 1'b0;
      value_o   <= '0;
      overrun_o <= 1'b0;
      exited_o  <= 1'b0;
    end else begin
      if (accept) begin
        pending_o <= 1'b1;
        value_o   <= wdata_i;
      end else if (clear_i) begin
        pending_o <= 1'b0;
      end
      if (write_valid && !accept) begin
        overrun_o <= 1'b1;
      end
      if (set_exited_i) begin
        exited_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sim_exit_ctrl.sv
// Multi-channel tohost poller: forwards syscalls to the host, decodes exits, watchdog.
module sim_exit_ctrl
  import sim_exit_pkg::*;
#(
  parameter int unsigned NumChannels   = 4,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned PollCycles    = 200,
  parameter int unsigned TimeoutCycles = 0,
  parameter bit          FailFast      = 1'b1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumChannels-1:0]                tohost_we_i,
  input  logic [NumChannels-1:0][DataWidth-1:0] tohost_wdata_i,
  output logic                                  host_req_valid_o,
  input  logic                                  host_req_ready_i,
  output logic [idx_width(NumChannels)-1:0]     host_req_chan_o,
  output logic [DataWidth-1:0]                  host_req_data_o,
  input  logic                                  host_rsp_valid_i,
  input  logic [DataWidth-1:0]                  host_rsp_data_i,
  output logic [NumChannels-1:0]                fromhost_valid_o,
  output logic [DataWidth-1:0]                  fromhost_data_o,
  output logic [NumChannels-1:0]                exited_o,
  output logic [NumChannels-1:0]                overrun_o,
  output logic                                  done_o,
  output logic                                  fail_o,
  output logic                                  timeout_o,
  output logic [DataWidth-2:0]                  exit_code_o
);

  localparam int unsigned ChanW = idx_width(NumChannels);
  localparam int unsigned CntW  = idx_width(PollCycles);

  typedef struct packed {
    logic [ChanW-1:0]     chan;
    logic [DataWidth-1:0] data;
  } host_req_t;

  state_e                                state_q, state_d;
  logic [CntW-1:0]                       poll_cnt_q;
  logic                                  tick;
  logic [ChanW-1:0]                      ptr_q;
  host_req_t                             req_q;
  logic [NumChannels-1:0]                pending;
  logic [NumChannels-1:0][DataWidth-1:0] value;
  logic [NumChannels-1:0]                eligible;
  logic [NumChannels-1:0]                clear;
  logic [NumChannels-1:0]                set_exited;
  logic [ChanW-1:0]                      cand;
  logic [ChanW-1:0]                      pick;
  logic                                  pick_valid;
  logic [ChanW-1:0]                      next_ptr;
  logic [DataWidth-1:0]                  sel_value;
  logic [DataWidth-2:0]                  sel_code;
  logic                                  sel_exit;
  logic                                  exit_finish;
  logic                                  wd_expired;
  logic                                  timeout_fire;
  logic [NumChannels-1:0]                fh_pulse_d;

  for (genvar g = 0; g < NumChannels; g++) begin : g_mbox
    sim_exit_mailbox #(
      .DataWidth(DataWidth)
    ) u_mbox (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .we_i        (tohost_we_i[g]),
      .wdata_i     (tohost_wdata_i[g]),
      .clear_i     (clear[g]),
      .set_exited_i(set_exited[g]),
      .pending_o   (pending[g]),
      .value_o     (value[g]),
      .overrun_o   (overrun_o[g]),
      .exited_o    (exited_o[g])
    );
  end

  if (TimeoutCycles > 0) begin : g_wd
    localparam int unsigned WdW = idx_width(TimeoutCycles + 1);
    localparam logic [WdW-1:0] WdMax = WdW'(TimeoutCycles);
    logic [WdW-1:0] wd_cnt_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wd_cnt_q <= '0;
      end else if (wd_cnt_q != WdMax) begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end
    end

    assign wd_expired = (wd_cnt_q == WdMax);
  end else begin : g_no_wd
    assign wd_expired = 1'b0;
  end

  assign tick         = (poll_cnt_q == CntW'(PollCycles - 1));
  assign timeout_fire = wd_expired && (state_q != DONE);
  assign eligible     = pending & ~exited_o;

  // Round-robin: walk from the farthest candidate back to ptr so the
  // closest eligible channel is the last (winning) assignment.
  always_comb begin
    cand       = '0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int unsigned k = NumChannels; k > 0; k--) begin
      cand = ChanW'((32'(ptr_q) + k - 1) % NumChannels);
      if (eligible[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    next_ptr    = (pick == ChanW'(NumChannels - 1)) ? '0 : pick + 1'b1;
    sel_value   = value[pick];
    sel_exit    = sel_value[0];
    sel_code    = sel_value[DataWidth-1:1];
    exit_finish = (FailFast && (sel_code != '0))
               || (&(exited_o | (NumChannels'(1) << pick)));
  end

  always_comb begin
    state_d    = state_q;
    clear      = '0;
    set_exited = '0;
    fh_pulse_d = '0;
    unique case (state_q)
      RUN: begin
        if (tick && (|eligible)) state_d = SCAN;
      end
      SCAN: begin
        if (!pick_valid) begin
          state_d = RUN;
        end else if (sel_exit) begin
          clear[pick]      = 1'b1;
          set_exited[pick] = 1'b1;
          state_d          = exit_finish ? DONE : RUN;
        end else begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (host_req_ready_i) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (host_rsp_valid_i) begin
          clear[req_q.chan]      = 1'b1;
          fh_pulse_d[req_q.chan] = 1'b1;
          state_d                = RUN;
        end
      end
      DONE: ;
      default: state_d = RUN;
    endcase
    // The watchdog pre-empts whatever the FSM was doing this cycle.
    if (timeout_fire) begin
      state_d    = DONE;
      clear      = '0;
      set_exited = '0;
      fh_pulse_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= RUN;
      poll_cnt_q       <= '0;
      ptr_q            <= '0;
      req_q            <= '0;
      exit_code_o      <= '0;
      timeout_o        <= 1'b0;
      fromhost_valid_o <= '0;
      fromhost_data_o  <= '0;
    end else begin
      state_q          <= state_d;
      fromhost_valid_o <= fh_pulse_d;
      if (state_q != DONE) begin
        poll_cnt_q <= tick ? '0 : poll_cnt_q + 1'b1;
      end
      if (|fh_pulse_d) begin
        fromhost_data_o <= host_rsp_data_i;
      end
      if (timeout_fire) begin
        timeout_o   <= 1'b1;
        exit_code_o <= '1;
      end else if (state_q == SCAN && pick_valid) begin
        ptr_q <= next_ptr;
        if (!sel_exit) begin
          req_q.chan <= pick;
          req_q.data <= sel_value;
        end else if ((exit_code_o == '0) && (sel_code != '0)) begin
          exit_code_o <= sel_code;
        end
      end
    end
  end

  assign host_req_valid_o = (state_q == REQ);
  assign host_req_chan_o  = req_q.chan;
  assign host_req_data_o  = req_q.data;
  assign done_o           = (state_q == DONE);
  assign fail_o           = done_o && ((exit_code_o != '0) || timeout_o);

endmodule

// File: tb/tb_sim_exit_ctrl.sv
// Randomized + directed bench for sim_exit_ctrl against a behavioural mailbox model.
module tb_sim_exit_ctrl;

  localparam int NCH    = 4;
  localparam int POLL   = 8;
  localparam int POLL_B = 20;
  localparam int TMO_B  = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Instance A: four channels, fast polling, no watchdog
  logic                 rst;
  logic [3:0]           we;
  logic [3:0][63:0]     wdata;
  logic                 ready, rsp_valid;
  logic [63:0]          rsp_data;
  logic                 req_valid;
  logic [1:0]           req_chan;
  logic [63:0]          req_data;
  logic [3:0]           fh_valid;
  logic [63:0]          fh_data;
  logic [3:0]           exited, overrun;
  logic                 done, fail, timeout;
  logic [62:0]          exit_code;

  sim_exit_ctrl #(
    .NumChannels(NCH), .DataWidth(64), .PollCycles(POLL), .TimeoutCycles(0), .FailFast(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .tohost_we_i(we), .tohost_wdata_i(wdata),
    .host_req_valid_o(req_valid), .host_req_ready_i(ready), .host_req_chan_o(req_chan),
    .host_req_data_o(req_data), .host_rsp_valid_i(rsp_valid), .host_rsp_data_i(rsp_data),
    .fromhost_valid_o(fh_valid), .fromhost_data_o(fh_data), .exited_o(exited),
    .overrun_o(overrun), .done_o(done), .fail_o(fail), .timeout_o(timeout),
    .exit_code_o(exit_code)
  );

  // Instance B: single channel with watchdog
  logic             rst_b, we_b, ready_b, rsp_valid_b;
  logic [0:0][63:0] wdata_b;
  logic [63:0]      rsp_data_b;
  logic             req_valid_b;
  logic [0:0]       req_chan_b;
  logic [63:0]      req_data_b, fh_data_b;
  logic [0:0]       fh_valid_b, exited_b, overrun_b;
  logic             done_b, fail_b, timeout_b;
  logic [62:0]      exit_code_b;

  sim_exit_ctrl #(
    .NumChannels(1), .DataWidth(64), .PollCycles(POLL_B), .TimeoutCycles(TMO_B), .FailFast(1'b1)
  ) dut_wd (
    .clk_i(clk), .rst_i(rst_b), .tohost_we_i(we_b), .tohost_wdata_i(wdata_b),
    .host_req_valid_o(req_valid_b), .host_req_ready_i(ready_b), .host_req_chan_o(req_chan_b),
    .host_req_data_o(req_data_b), .host_rsp_valid_i(rsp_valid_b), .host_rsp_data_i(rsp_data_b),
    .fromhost_valid_o(fh_valid_b), .fromhost_data_o(fh_data_b), .exited_o(exited_b),
    .overrun_o(overrun_b), .done_o(done_b), .fail_o(fail_b), .timeout_o(timeout_b),
    .exit_code_o(exit_code_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model of instance A: what the host would observe of each mailbox
  typedef enum {M_IDLE, M_PICKING, M_OFFERING, M_AWAITING, M_FINISHED} mphase_t;
  mphase_t     m_ph;
  bit [3:0]    m_pend, m_ovr, m_ext, m_fh;
  logic [63:0] m_val [4];
  int          m_cnt, m_ptr, m_ch;
  logic [63:0] m_data, m_fhd;
  logic [62:0] m_code;

  always @(posedge clk) begin : model
    bit [3:0]    clr;
    mphase_t     nph;
    int          c;
    logic [62:0] code;
    if (rst) begin
      m_ph = M_IDLE; m_pend = '0; m_ovr = '0; m_ext = '0; m_fh = '0; m_fhd = '0;
      m_cnt = 0; m_ptr = 0; m_ch = 0; m_data = '0; m_code = '0;
      for (int i = 0; i < NCH; i++) m_val[i] = '0;
    end else begin
      clr = '0; nph = m_ph; m_fh = '0;
      case (m_ph)
        M_IDLE: if (m_cnt == POLL - 1 && (m_pend & ~m_ext) != 0) nph = M_PICKING;
        M_PICKING: begin
          c = -1;
          for (int k = 0; k < NCH; k++)
            if (c < 0 && m_pend[(m_ptr + k) % NCH] && !m_ext[(m_ptr + k) % NCH]) c = (m_ptr + k) % NCH;
          if (c < 0) nph = M_IDLE;
          else begin
            m_ptr = (c + 1) % NCH;
            if (m_val[c][0]) begin
              code = m_val[c][63:1];
              clr[c] = 1'b1; m_ext[c] = 1'b1;
              if (m_code == 0) m_code = code;
              nph = (code != 0 || m_ext == 4'hF) ? M_FINISHED : M_IDLE;
            end else begin
              m_ch = c; m_data = m_val[c]; nph = M_OFFERING;
            end
          end
        end
        M_OFFERING: if (ready) nph = M_AWAITING;
        M_AWAITING: if (rsp_valid) begin
          m_fh[m_ch] = 1'b1; m_fhd = rsp_data; clr[m_ch] = 1'b1; nph = M_IDLE;
        end
        default: ;
      endcase
      for (int i = 0; i < NCH; i++) begin
        if (we[i] && wdata[i] != 0) begin
          if (!m_pend[i] || clr[i]) begin m_pend[i] = 1'b1; m_val[i] = wdata[i]; end
          else m_ovr[i] = 1'b1;
        end else if (clr[i]) m_pend[i] = 1'b0;
      end
      if (m_ph != M_FINISHED) m_cnt = (m_cnt + 1) % POLL;
      m_ph = nph;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("exited", 64'(exited), 64'(m_ext));
      check("overrun", 64'(overrun), 64'(m_ovr));
      check("done", 64'(done), 64'(m_ph == M_FINISHED));
      check("fail", 64'(fail), 64'(m_ph == M_FINISHED && m_code != 0));
      check("timeout", 64'(timeout), 64'(0));
      check("exit_code", 64'(exit_code), 64'(m_code));
      check("req_valid", 64'(req_valid), 64'(m_ph == M_OFFERING));
      if (m_ph == M_OFFERING) begin
        check("req_chan", 64'(req_chan), 64'(m_ch));
        check("req_data", req_data, m_data);
      end
      check("fh_valid", 64'(fh_valid), 64'(m_fh));
      if (m_fh != 0) check("fh_data", fh_data, m_fhd);
    end
  end

  task automatic idle_a();
    we = '0; wdata = '0; ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
  endtask

  task automatic reset_a();
    idle_a();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic reset_b();
    rst_b = 1'b1; we_b = 1'b0; wdata_b = '0;
    @(negedge clk); @(negedge clk);
    rst_b = 1'b0;
  endtask

  task automatic wait_req(input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (req_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("req_valid_within_bound", 64'(ok), 64'(1));
  endtask

  task automatic serve(input int ch, input logic [63:0] d);
    logic [63:0] r;
    wait_req(2 * POLL + 6);
    check("serve_chan", 64'(req_chan), 64'(ch));
    check("serve_data", req_data, d);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    r = {$urandom, $urandom};
    rsp_valid = 1'b1; rsp_data = r;
    @(negedge clk);
    rsp_valid = 1'b0;
    check("serve_fh_valid", 64'(fh_valid), 64'(4'b0001 << ch));
    check("serve_fh_data", fh_data, r);
  endtask

  initial begin : watchdog_guard
    #2000000;
    $display("FAIL global_time_limit: got expired, expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "time limit");
  end

  initial begin : stim
    bit ok, seen;
    int r;
    rst_b = 1'b1; we_b = 1'b0; wdata_b = '0; ready_b = 1'b0; rsp_valid_b = 1'b0; rsp_data_b = '0;
    reset_a();

    // Reset state
    check("rst_req_valid", 64'(req_valid), 64'(0));
    check("rst_fh_valid", 64'(fh_valid), 64'(0));
    check("rst_exited", 64'(exited), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_fail", 64'(fail), 64'(0));
    check("rst_exit_code", 64'(exit_code), 64'(0));
    chk_en = 1'b1;

    // Failure with FailFast: code 3 on channel 2
    reset_a();
    we[2] = 1'b1; wdata[2] = 64'h7;
    @(negedge clk);
    idle_a();
    ok = 1'b0;
    for (int i = 0; i < 2 * POLL + 4; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("ff_done", 64'(ok), 64'(1));
    check("ff_fail", 64'(fail), 64'(1));
    check("ff_exit_code", 64'(exit_code), 64'(3));
    check("ff_exited", 64'(exited), 64'(4'b0100));

    // Syscall with host stalling ready
    reset_a();
    we[1] = 1'b1; wdata[1] = 64'h8000_1000;
    @(negedge clk);
    idle_a();
    wait_req(2 * POLL + 4);
    check("sc_chan", 64'(req_chan), 64'(1));
    check("sc_data", req_data, 64'h8000_1000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("sc_hold_valid", 64'(req_valid), 64'(1));
      check("sc_hold_chan", 64'(req_chan), 64'(1));
      check("sc_hold_data", req_data, 64'h8000_1000);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("sc_valid_dropped", 64'(req_valid), 64'(0));
    rsp_valid = 1'b1; rsp_data = 64'h1;
    @(negedge clk);
    rsp_valid = 1'b0;
    check("sc_fh_valid", 64'(fh_valid), 64'(4'b0010));
    check("sc_fh_data", fh_data, 64'h1);
    @(negedge clk);
    check("sc_fh_one_cycle", 64'(fh_valid), 64'(0));

    // Round-robin and overrun
    reset_a();
    we[0] = 1'b1; wdata[0] = 64'h100; we[3] = 1'b1; wdata[3] = 64'h300;
    @(negedge clk);
    we[3] = 1'b0; wdata[0] = 64'h200;
    @(negedge clk);
    idle_a();
    check("rr_overrun", 64'(overrun), 64'(4'b0001));
    serve(0, 64'h100);
    serve(3, 64'h300);

    // Reset while a request is outstanding
    reset_a();
    we[2] = 1'b1; wdata[2] = 64'h40;
    @(negedge clk);
    idle_a();
    wait_req(2 * POLL + 4);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req_valid", 64'(req_valid), 64'(0));
    check("mid_rst_req_chan", 64'(req_chan), 64'(0));
    check("mid_rst_req_data", req_data, 64'(0));
    check("mid_rst_fh_valid", 64'(fh_valid), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3 * POLL; i++) begin
      @(negedge clk);
      if (req_valid) seen = 1'b1;
    end
    check("mid_rst_no_pending", 64'(seen), 64'(0));

    // Randomized episodes
    for (int ep = 0; ep < 20; ep++) begin
      reset_a();
      for (int cyc = 0; cyc < 300; cyc++) begin
        for (int c = 0; c < NCH; c++) begin
          we[c] = ($urandom_range(0, 9) == 0);
          r = $urandom_range(0, 63);
          if (r == 0)      wdata[c] = '0;
          else if (r == 1) wdata[c] = {61'b0, 2'($urandom_range(0, 3)), 1'b1};
          else             wdata[c] = ({$urandom, $urandom} & ~64'h1) | 64'h2;
        end
        ready     = ($urandom_range(0, 1) == 1);
        rsp_valid = ($urandom_range(0, 2) == 0);
        rsp_data  = {$urandom, $urandom};
        @(negedge clk);
      end
    end
    idle_a();
    chk_en = 1'b0;

    // Single channel clean exit
    reset_b();
    we_b = 1'b1; wdata_b[0] = 64'h1;
    @(negedge clk);
    we_b = 1'b0; wdata_b = '0;
    ok = 1'b0;
    for (int i = 0; i < POLL_B + 2; i++) begin
      if (done_b) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("ok_done", 64'(ok), 64'(1));
    check("ok_fail", 64'(fail_b), 64'(0));
    check("ok_exit_code", 64'(exit_code_b), 64'(0));
    check("ok_exited", 64'(exited_b), 64'(1));
    check("ok_timeout", 64'(timeout_b), 64'(0));

    // Watchdog: expires at cycle TMO_B+1 after reset
    reset_b();
    repeat (TMO_B) @(negedge clk);
    check("wd_not_yet", 64'(timeout_b), 64'(0));
    check("wd_not_done", 64'(done_b), 64'(0));
    @(negedge clk);
    check("wd_timeout", 64'(timeout_b), 64'(1));
    check("wd_done", 64'(done_b), 64'(1));
    check("wd_fail", 64'(fail_b), 64'(1));
    check("wd_exit_code", 64'(exit_code_b), {1'b0, {63{1'b1}}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
